// File: rtl/ab_input_debounce.sv
// Two-channel synchronizer and debouncer that produces clean a/b levels and rise pulses for the AND gate.
// Optional AB_DEBOUNCE_FALL_EN adds a_fall/b_fall one-cycle fall pulses.
module ab_input_debounce #(
  parameter  int SYNC_STAGES     = 2,
  parameter  int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic a_raw,
  input  logic b_raw,
  output logic a_out,
  output logic b_out,
  output logic a_rise,
  output logic b_rise,
`ifdef AB_DEBOUNCE_FALL_EN
  output logic a_fall,
  output logic b_fall,
`endif
  output logic stable
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]                  raw;
  logic [1:0][SYNC_STAGES-1:0] sync_q, sync_d;
  logic [1:0][CNT_W-1:0]       cnt_q, cnt_d;
  logic [1:0]                  out_q, out_d;
  logic [1:0]                  rise_q, rise_d;
`ifdef AB_DEBOUNCE_FALL_EN
  logic [1:0]                  fall_q, fall_d;
`endif

  assign raw = {b_raw, a_raw};

  always_comb begin
    sync_d = sync_q;
    cnt_d  = cnt_q;
    out_d  = out_q;
    for (int ch = 0; ch < 2; ch++) begin
      sync_d[ch] = {sync_q[ch][SYNC_STAGES-2:0], raw[ch]};
      // Any cycle where the synchronized level agrees with the output discards the pending count.
      if (sync_q[ch][SYNC_STAGES-1] == out_q[ch]) begin
        cnt_d[ch] = '0;
      end else if (cnt_q[ch] == CNT_MAX) begin
        out_d[ch] = sync_q[ch][SYNC_STAGES-1];
        cnt_d[ch] = '0;
      end else begin
        cnt_d[ch] = cnt_q[ch] + CNT_W'(1);
      end
    end
    rise_d = out_d & ~out_q;
  end

`ifdef AB_DEBOUNCE_FALL_EN
  always_comb begin
    fall_d = ~out_d & out_q;
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= '0;
      cnt_q  <= '0;
      out_q  <= '0;
      rise_q <= '0;
    end else begin
      sync_q <= sync_d;
      cnt_q  <= cnt_d;
      out_q  <= out_d;
      rise_q <= rise_d;
    end
  end

`ifdef AB_DEBOUNCE_FALL_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fall_q <= '0;
    end else begin
      fall_q <= fall_d;
    end
  end

  assign a_fall = fall_q[0];
  assign b_fall = fall_q[1];
`endif

  assign a_out  = out_q[0];
  assign b_out  = out_q[1];
  assign a_rise = rise_q[0];
  assign b_rise = rise_q[1];
  assign stable = (cnt_q[0] == '0) && (cnt_q[1] == '0);

endmodule

// File: doc/ab_input_debounce.md
Name: ab_input_debounce

Overview:
- Front-end conditioning stage for the two-input AND gate.
- Takes raw, asynchronous, bouncy `a_raw`/`b_raw` levels (switches, test pins). Synchronizes each into the `clk` domain and debounces it with a per-channel stability counter.
- Drives clean `a_out`/`b_out` levels into the AND gate's `a`/`b` inputs.
- Also flags clean rising edges so downstream logic can count events.

Parameters:
- `SYNC_STAGES`, 2: flip-flops in each synchronizer chain; legal range >= 2.
- `DEBOUNCE_CYCLES`, 4: consecutive cycles the synchronized level must differ from the output before the output follows; legal range >= 1.
- `CNT_W`, `$clog2(DEBOUNCE_CYCLES+1)`: stability counter width; derived, not overridden.

Ports:
- `clk`  input  1  single clock, rising edge
- `rst`  input  1  asynchronous, active-high reset
- `a_raw`  input  1  raw asynchronous level, channel A
- `b_raw`  input  1  raw asynchronous level, channel B
- `a_out`  output  1  debounced level A, registered; feeds AND input `a`
- `b_out`  output  1  debounced level B, registered; feeds AND input `b`
- `a_rise`  output  1  one-cycle pulse, asserted in the cycle `a_out` first reads 1
- `b_rise`  output  1  one-cycle pulse, asserted in the cycle `b_out` first reads 1
- `stable`  output  1  1 when both stability counters are 0, i.e. no pending change

Behaviour:
- Reset (async assert, released synchronously by `clk`): all sync flops, counters, `a_out`, `b_out`, `a_rise`, `b_rise` = 0; `stable` = 1.
- Reset mid-operation: outputs drop to reset values immediately, without waiting for a clock edge; pending counts are discarded.
- Channels A and B are identical and fully independent. The per-channel description below uses `x`.
- Synchronizer: `x_raw` shifts through `SYNC_STAGES` flops. `x_sync` is the last stage. No logic sits between stages.
- Counter, each rising edge:
  - `x_sync == x_out`: counter <= 0.
  - `x_sync != x_out` and counter < `DEBOUNCE_CYCLES-1`: counter <= counter + 1.
  - `x_sync != x_out` and counter == `DEBOUNCE_CYCLES-1`: `x_out` <= `x_sync`, counter <= 0.
- Latency: new raw level held steady changes `x_out` on the (`SYNC_STAGES`+`DEBOUNCE_CYCLES`)-th rising edge that samples it, counting the first sampling edge as 1. With defaults, that is the 6th edge.
- Glitch rejection: a mismatch lasting fewer than `DEBOUNCE_CYCLES` cycles at `x_sync` leaves `x_out` unchanged and resets the counter.
- `DEBOUNCE_CYCLES`=1: `x_out` follows `x_sync` one edge later (pure synchronizer).
- `x_rise` is registered. It is 1 exactly in the cycle where `x_out` is 1 and was 0 the previous cycle, and 0 otherwise.
  - Never asserted out of reset unless `x_out` actually rises.
  - Back-to-back toggles (raw 1 then 0 then 1, each held long enough) give one pulse per rise.
- Simultaneous A/B changes: no interaction. Both outputs may change on the same edge; both rise pulses may assert together.
- `stable` is combinational from the two counters: `stable = (cntA==0) && (cntB==0)`.
  - Goes 0 the cycle after a mismatch is first seen.
  - Returns to 1 the same cycle the output updates or the glitch clears.
- Counter never exceeds `DEBOUNCE_CYCLES-1`; no wrap-around is possible.

Optional Feature:
- Macro: `AB_DEBOUNCE_FALL_EN`.
- Defined: adds output ports `a_fall` and `b_fall` (1-bit each).
  - Each is a registered one-cycle pulse in the cycle `x_out` first reads 0 after being 1.
  - Reset value 0; same timing rules as `x_rise`.
- Not defined: these ports and their logic do not exist. All other behaviour is identical.

Test Plan:
- Reset with `a_raw`=`b_raw`=1 held, release at edge 0 → `a_out`/`b_out` stay 0 through edge 5, both = 1 after edge 6; `a_rise`=`b_rise`=1 for exactly that one cycle.
- `a_raw` 0→1 held (defaults) → `a_out` rises on 6th sampling edge; `stable`=0 during the count, 1 after; `b_out` unaffected.
- `a_raw` pulse of 3 cycles then back to 0 → `a_out` stays 0, `a_rise` never asserts, `stable` returns to 1.
- `a_raw` bounce 1,0,1,1,1,1,1 (one cycle each) → counter restarts after the 0; `a_out` rises 6 edges after the last 0→1 transition; single `a_rise` pulse.
- Assert `rst` asynchronously mid-count with `a_out`=1 → `a_out`=0, `a_rise`=0, `stable`=1 before the next clock edge; recount after release.
- With `AB_DEBOUNCE_FALL_EN` defined: `b_raw` 1→0 held after `b_out`=1 → `b_fall` pulses one cycle when `b_out` drops, `b_rise` stays 0.
